// File: rtl/phase_decoder_pkg.sv
// Shared types and constants for the phase decoder.
package phase_decoder_pkg;

   typedef enum logic [1:0] {
      StHunt,
      StTrack,
      StLock,
      StStatic
   } state_e;

   typedef enum logic [1:0] {
      ClsOnehot,
      ClsZero,
      ClsOnes,
      ClsInvalid
   } cls_e;

   localparam logic [1:0] MODE_UNKNOWN     = 2'b00;
   localparam logic [1:0] MODE_ROTATING    = 2'b01;
   localparam logic [1:0] MODE_FORCED_LOW  = 2'b10;
   localparam logic [1:0] MODE_FORCED_HIGH = 2'b11;

   localparam int unsigned LOCK_RUN   = 4;
   localparam int unsigned STATIC_RUN = 8;
   localparam int unsigned ERR_CNT_W  = 8;

   // Line mode reported for a static level of the given class
   function automatic logic [1:0] static_mode(cls_e c);
      return (c == ClsZero) ? MODE_FORCED_LOW : MODE_FORCED_HIGH;
   endfunction

endpackage

// File: rtl/phase_decoder_if.sv
// Phase lines in, decoded status out.
interface phase_decoder_if;
   import phase_decoder_pkg::*;

   logic                 IN1;
   logic                 IN2;
   logic                 IN3;
   logic                 IN4;
   logic [1:0]           MODE;
   logic [1:0]           PHASE;
   logic                 LOCKED;
   logic                 ERR;
   logic [ERR_CNT_W-1:0] ERR_CNT;

   modport master (
      output IN1, IN2, IN3, IN4,
      input  MODE, PHASE, LOCKED, ERR, ERR_CNT
   );

   modport slave (
      input  IN1, IN2, IN3, IN4,
      output MODE, PHASE, LOCKED, ERR, ERR_CNT
   );

endinterface

// File: rtl/phase_classify.sv
// Classifies a 4-bit phase sample as one-hot, all-zero, all-one or invalid.
module phase_classify
   import phase_decoder_pkg::*;
(
   input  logic [3:0] smp,
   output cls_e       cls,
   output logic [1:0] idx
);

   // Decode the sample; idx is meaningful only for ClsOnehot
   always_comb begin
      cls = ClsInvalid;
      idx = 2'd0;
      unique case (smp)
         4'b0001: begin cls = ClsOnehot; idx = 2'd0; end
         4'b0010: begin cls = ClsOnehot; idx = 2'd1; end
         4'b0100: begin cls = ClsOnehot; idx = 2'd2; end
         4'b1000: begin cls = ClsOnehot; idx = 2'd3; end
         4'b0000: cls = ClsZero;
         4'b1111: cls = ClsOnes;
         default: cls = ClsInvalid;
      endcase
   end

endmodule

// File: rtl/phase_decoder.sv
// Tracks a rotating four-phase sequence, detects static levels and counts errors.
module phase_decoder
   import phase_decoder_pkg::*;
(
   input logic            CLK,
   input logic            RST_N,
   phase_decoder_if.slave bus
);

   logic [3:0]           smp_q;
   logic                 smp_vld_q;  // smp_q holds a real capture, not the reset value
   state_e               state_q;
   logic [2:0]           run_q;
   logic [3:0]           srun_q;
   cls_e                 sval_q;
   logic [1:0]           prev_q;
   logic [1:0]           mode_q;
   logic [1:0]           phase_q;
   logic                 locked_q;
   logic                 err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   cls_e       cls;
   logic [1:0] idx;
   logic       succ;
   logic       err_det;

   phase_classify u_classify (
      .smp (smp_q),
      .cls (cls),
      .idx (idx)
   );

   // Successor check and error detection; lock loss plus invalid is still one error
   always_comb begin
      succ    = (cls == ClsOnehot) && (idx == prev_q + 2'd1);
      err_det = (cls == ClsInvalid) || ((state_q == StLock) && !succ);
   end

   // Sample capture, decoder FSM, counters and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         smp_q     <= 4'b0000;
         smp_vld_q <= 1'b0;
         state_q   <= StHunt;
         run_q     <= '0;
         srun_q    <= '0;
         sval_q    <= ClsZero;
         prev_q    <= 2'd0;
         mode_q    <= MODE_UNKNOWN;
         phase_q   <= 2'd0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         smp_q     <= {bus.IN4, bus.IN3, bus.IN2, bus.IN1};
         smp_vld_q <= 1'b1;
         err_q     <= 1'b0;
         if (smp_vld_q) begin
            if (err_det) begin
               err_q <= 1'b1;
               if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
            end
            unique case (state_q)
               StHunt: begin
                  unique case (cls)
                     ClsOnehot: begin
                        state_q <= StTrack;
                        run_q   <= 3'd1;
                        prev_q  <= idx;
                        srun_q  <= '0;
                     end
                     ClsZero, ClsOnes: begin
                        if ((srun_q != '0) && (sval_q == cls)) begin
                           srun_q <= srun_q + 4'd1;
                           if (srun_q + 4'd1 == 4'(STATIC_RUN)) begin
                              state_q <= StStatic;
                              mode_q  <= static_mode(cls);
                           end
                        end else begin
                           srun_q <= 4'd1;
                           sval_q <= cls;
                        end
                     end
                     default: srun_q <= '0;
                  endcase
               end
               StTrack: begin
                  if (cls == ClsOnehot) begin
                     prev_q <= idx;
                     if (succ) begin
                        run_q <= run_q + 3'd1;
                        if (run_q + 3'd1 == 3'(LOCK_RUN)) begin
                           state_q  <= StLock;
                           locked_q <= 1'b1;
                           mode_q   <= MODE_ROTATING;
                           phase_q  <= idx;
                        end
                     end else begin
                        run_q <= 3'd1;
                     end
                  end else begin
                     state_q <= StHunt;
                     run_q   <= '0;
                  end
               end
               StLock: begin
                  if (succ) begin
                     prev_q  <= idx;
                     phase_q <= idx;
                  end else begin
                     state_q  <= StHunt;
                     locked_q <= 1'b0;
                     mode_q   <= MODE_UNKNOWN;
                     run_q    <= '0;
                  end
               end
               StStatic: begin
                  if (cls != sval_q) begin
                     state_q <= StHunt;
                     mode_q  <= MODE_UNKNOWN;
                     srun_q  <= '0;
                  end
               end
               default: state_q <= StHunt;
            endcase
         end
      end
   end

   assign bus.MODE    = mode_q;
   assign bus.PHASE   = phase_q;
   assign bus.LOCKED  = locked_q;
   assign bus.ERR     = err_q;
   assign bus.ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_phase_decoder.sv
// Bench for phase_decoder: directed phase patterns, a behavioural model checked
// on every falling edge, and literal checks at hand-computed edges.
module tb_phase_decoder;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;

   phase_decoder_if bus ();

   phase_decoder dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   logic [3:0] rot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   // Behavioural model state
   logic [3:0] m_smp      = 4'b0000;
   bit         m_have     = 0;
   bit         m_locked   = 0;
   bit         m_static   = 0;
   int         m_chain    = 0;
   int         m_same     = 0;
   int         m_prev     = 0;
   logic [3:0] m_stat_val = 4'b0000;
   int         exp_mode   = 0;
   int         exp_phase  = 0;
   int         exp_err    = 0;
   int         exp_cnt    = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [3:0] p);
      bus.IN1 = p[0];
      bus.IN2 = p[1];
      bus.IN3 = p[2];
      bus.IN4 = p[3];
   endtask

   // Advance one rising edge, then present the next pattern
   task automatic tick(input logic [3:0] nxt);
      @(posedge CLK);
      #1;
      set_in(nxt);
   endtask

   // One evaluated sample: error rules, lock hysteresis, static-level runs
   task automatic model_eval(input logic [3:0] s);
      bit oh;
      bit inval;
      bit succ;
      int ix;
      oh    = ($countones(s) == 1);
      inval = !oh && (s != 4'b0000) && (s != 4'b1111);
      ix    = 0;
      for (int i = 0; i < 4; i++) if (s[i]) ix = i;
      succ    = oh && (ix == (m_prev + 1) % 4);
      exp_err = (inval || (m_locked && !succ)) ? 1 : 0;
      if (exp_err == 1 && exp_cnt < 255) exp_cnt++;
      if (m_locked) begin
         if (succ) begin
            exp_phase = ix;
            m_prev    = ix;
         end else begin
            m_locked = 0;
            m_chain  = 0;
         end
      end else if (m_static) begin
         if (s != m_stat_val) begin
            m_static = 0;
            m_same   = 0;
         end
      end else if (oh) begin
         m_chain = (m_chain > 0 && succ) ? m_chain + 1 : 1;
         m_prev  = ix;
         m_same  = 0;
         if (m_chain == 4) begin
            m_locked  = 1;
            exp_phase = ix;
         end
      end else if (m_chain > 0) begin
         m_chain = 0;
      end else if (!inval) begin
         m_same     = (m_same > 0 && s == m_stat_val) ? m_same + 1 : 1;
         m_stat_val = s;
         if (m_same == 8) m_static = 1;
      end else begin
         m_same = 0;
      end
      exp_mode = m_locked ? 1 : (m_static ? ((m_stat_val == 4'b0000) ? 2 : 3) : 0);
   endtask

   // Model update: one-edge sample pipeline, reset clears everything
   initial begin
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            m_have = 0; m_locked = 0; m_static = 0; m_chain = 0; m_same = 0;
            m_prev = 0; m_stat_val = 4'b0000;
            exp_mode = 0; exp_phase = 0; exp_err = 0; exp_cnt = 0;
         end else begin
            if (m_have) model_eval(m_smp);
            else exp_err = 0;
            m_smp  = {bus.IN4, bus.IN3, bus.IN2, bus.IN1};
            m_have = 1;
         end
      end
   end

   // Compare DUT against model on every falling edge out of reset
   initial begin
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            chk("mode", int'(bus.MODE), exp_mode);
            chk("locked", int'(bus.LOCKED), int'(m_locked));
            chk("err", int'(bus.ERR), exp_err);
            chk("err_cnt", int'(bus.ERR_CNT), exp_cnt);
            if (m_locked) chk("phase", int'(bus.PHASE), exp_phase);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(4'b0001);
      #12;
      chk("rst_mode", int'(bus.MODE), 0);
      chk("rst_locked", int'(bus.LOCKED), 0);
      chk("rst_err", int'(bus.ERR), 0);
      chk("rst_cnt", int'(bus.ERR_CNT), 0);
      chk("rst_phase", int'(bus.PHASE), 0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Rotation from the first edge: locked at edge 5, phase 3 there
      for (int k = 1; k <= 12; k++) begin
         tick(rot[k % 4]);
         if (k == 4) chk("e4_unlocked", int'(bus.LOCKED), 0);
         if (k == 5) begin
            chk("e5_locked", int'(bus.LOCKED), 1);
            chk("e5_mode", int'(bus.MODE), 1);
            chk("e5_phase", int'(bus.PHASE), 3);
         end
      end

      // Skip 0001 -> 0100 while locked, then relock after four good samples
      tick(4'b0100);
      tick(4'b1000);
      tick(4'b0001);
      chk("skip_locked", int'(bus.LOCKED), 0);
      chk("skip_err", int'(bus.ERR), 1);
      chk("skip_cnt", int'(bus.ERR_CNT), 1);
      tick(4'b0010);
      chk("skip_err_gone", int'(bus.ERR), 0);
      tick(4'b0100);
      tick(4'b1000);
      chk("relock_e18", int'(bus.LOCKED), 0);
      tick(4'b0001);
      chk("relock_e19", int'(bus.LOCKED), 1);
      chk("relock_phase", int'(bus.PHASE), 2);

      // Invalid while locked: one error, one count
      tick(4'b0011);
      tick(4'b1111);
      tick(4'b1111);
      chk("inv_lock_err", int'(bus.ERR), 1);
      chk("inv_lock_cnt", int'(bus.ERR_CNT), 2);
      chk("inv_lock_unlocked", int'(bus.LOCKED), 0);

      // Hold 1111: forced-high on the ninth edge after the first capture
      for (int k = 2; k <= 9; k++) begin
         tick(4'b1111);
         if (k == 8) chk("ones_e8", int'(bus.MODE), 0);
         if (k == 9) chk("ones_e9", int'(bus.MODE), 3);
      end
      tick(4'b0000);
      tick(4'b0000);
      chk("ones_hold", int'(bus.MODE), 3);
      tick(4'b0000);
      chk("ones_exit_mode", int'(bus.MODE), 0);
      chk("ones_exit_err", int'(bus.ERR), 0);

      // Reach forced-low, then leave it with invalid samples until saturation
      for (int k = 0; k < 10; k++) tick(4'b0000);
      chk("zero_static", int'(bus.MODE), 2);
      for (int k = 0; k < 300; k++) tick((k % 2 == 0) ? 4'b0101 : 4'b0110);
      tick(4'b0110);
      chk("sat_cnt", int'(bus.ERR_CNT), 255);

      // Lock again, then reset between edges
      for (int i = 0; i < 8; i++) tick(rot[i % 4]);
      chk("pre_rst_locked", int'(bus.LOCKED), 1);
      #2;
      RST_N = 1'b0;
      set_in(4'b0001);
      #1;
      chk("mid_rst_locked", int'(bus.LOCKED), 0);
      chk("mid_rst_mode", int'(bus.MODE), 0);
      chk("mid_rst_err", int'(bus.ERR), 0);
      chk("mid_rst_cnt", int'(bus.ERR_CNT), 0);
      chk("mid_rst_phase", int'(bus.PHASE), 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick(rot[k % 4]);
         if (k == 5) chk("post_rst_e5_locked", int'(bus.LOCKED), 1);
      end
      chk("post_rst_cnt", int'(bus.ERR_CNT), 0);

      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
